// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first through one full_adder.
// The b bit is inverted and the carry is seeded with 1; start/busy/done handshake.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (a_sr[0]),
        .b  (~b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
    assign res_next = {fa_s, res_sr[WIDTH-1:1]};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= fa_co;
                    if (cnt == LAST) begin
                        // The final sum bit is the result MSB used by the signed overflow test.
                        cnt    <= '0;
                        state  <= DONE;
                        diff   <= res_next;
                        borrow <= ~fa_co;
                        ovf    <= (a_msb ^ b_msb) & (fa_s ^ a_msb);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
// Expected values are hand-computed constants or a small arithmetic model.

module tb_serial_subtractor;
    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       borrow;
    logic       ovf;
    logic       busy;
    logic       done;

    int vectors;
    int miscompares;
    int cyc;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Launch one operation and return at the negedge where done is seen.
    task automatic launch(input logic [3:0] ta, input logic [3:0] tb_, output int busy_cycles, output bit got_done);
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_;
        busy_cycles = 0;
        got_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; a = 4'd7; b = 4'd2;
        repeat (2) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, diff, borrow, ovf} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h borrow=%b ovf=%b, want all 0",
                     busy, done, diff, borrow, ovf);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int bc; bit gd;
        launch(4'd9, 4'd3, bc, gd);
        vectors++;
        if (!gd || bc != 4) begin
            miscompares++;
            $display("FAIL basic_latency: got done=%b busy_cycles=%0d, want done=1 busy_cycles=4", gd, bc);
        end
        // 9-3: signed -7-3 overflows 4 bits
        vectors++;
        if ({diff, borrow, ovf} !== {4'd6, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL basic_result: got diff=%h borrow=%b ovf=%b, want diff=6 borrow=0 ovf=1", diff, borrow, ovf);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || diff !== 4'd6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=6", done, busy, diff);
        end
    endtask

    task automatic test_borrow_ovf;
        int bc; bit gd;
        launch(4'd3, 4'd9, bc, gd);
        vectors++;
        if (!gd || {diff, borrow, ovf} !== {4'hA, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_3_9: got done=%b diff=%h borrow=%b ovf=%b, want done=1 diff=a borrow=1 ovf=1",
                     gd, diff, borrow, ovf);
        end
        launch(4'd8, 4'd1, bc, gd);
        vectors++;
        if (!gd || {diff, borrow, ovf} !== {4'd7, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_8_1: got done=%b diff=%h borrow=%b ovf=%b, want done=1 diff=7 borrow=0 ovf=1",
                     gd, diff, borrow, ovf);
        end
    endtask

    task automatic test_edges;
        logic [3:0] ta [4] = '{4'd0, 4'd15, 4'd0, 4'd7};
        logic [3:0] tb_[4] = '{4'd0, 4'd15, 4'd1, 4'd8};
        logic [3:0] ed [4] = '{4'd0, 4'd0, 4'd15, 4'd15};
        logic       eb [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int bc; bit gd;
        for (int i = 0; i < 4; i++) begin
            launch(ta[i], tb_[i], bc, gd);
            vectors++;
            if (!gd || {diff, borrow, ovf} !== {ed[i], eb[i], eo[i]}) begin
                miscompares++;
                $display("FAIL edge_%0d: got done=%b diff=%h borrow=%b ovf=%b, want done=1 diff=%h borrow=%b ovf=%b",
                         i, gd, diff, borrow, ovf, ed[i], eb[i], eo[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        int ndone; logic [3:0] dseen;
        @(negedge clk);
        a = 4'd9; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 4'd2; b = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dseen = 4'hx;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                dseen = diff;
            end
            @(negedge clk);
        end
        vectors++;
        if (ndone != 1 || dseen !== 4'd6) begin
            miscompares++;
            $display("FAIL start_ignored: got %0d done pulses diff=%h, want 1 pulse diff=6", ndone, dseen);
        end
        vectors++;
        if (diff !== 4'd6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored_hold: got diff=%h busy=%b, want diff=6 busy=0", diff, busy);
        end
    endtask

    task automatic test_reset_abort;
        int bc; bit gd; int ndone;
        @(negedge clk);
        a = 4'd7; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_abort: got busy=%b done=%b diff=%h, want busy=0 done=0 diff=0", busy, done, diff);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        vectors++;
        if (ndone != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", ndone);
        end
        launch(4'd12, 4'd5, bc, gd);
        vectors++;
        if (!gd || bc != 4 || {diff, borrow, ovf} !== {4'd7, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL after_reset: got done=%b busy_cycles=%0d diff=%h borrow=%b ovf=%b, want 1 4 7 0 1",
                     gd, bc, diff, borrow, ovf);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] pa [8];
        logic [3:0] pb [8];
        logic [3:0] ed;
        logic       eb, eo;
        int last, stamp;
        bit seen;
        for (int i = 0; i < 8; i++) begin
            pa[i] = 4'($urandom_range(0, 15));
            pb[i] = 4'($urandom_range(0, 15));
        end
        last = 0;
        @(negedge clk);
        a = pa[0]; b = pb[0]; start = 1'b1;
        for (int k = 0; k < 8; k++) begin
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            vectors++;
            if (!seen) begin
                miscompares++;
                $display("FAIL b2b_timeout_%0d: got no done within 20 cycles, want done", k);
                start = 1'b0;
                return;
            end
            stamp = cyc;
            ed = pa[k] - pb[k];
            eb = (pa[k] < pb[k]);
            eo = (pa[k][3] != pb[k][3]) && (ed[3] != pa[k][3]);
            vectors++;
            if ({diff, borrow, ovf} !== {ed, eb, eo}) begin
                miscompares++;
                $display("FAIL b2b_result_%0d (%0d-%0d): got diff=%h borrow=%b ovf=%b, want diff=%h borrow=%b ovf=%b",
                         k, pa[k], pb[k], diff, borrow, ovf, ed, eb, eo);
            end
            if (k > 0) begin
                vectors++;
                if (stamp - last != 6) begin
                    miscompares++;
                    $display("FAIL b2b_period_%0d: got %0d cycles, want 6", k, stamp - last);
                end
            end
            last = stamp;
            if (k < 7) begin
                a = pa[k + 1]; b = pb[k + 1];
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0; start = 1'b0; a = '0; b = '0;
        test_reset;
        test_basic;
        test_borrow_ovf;
        test_edges;
        test_start_ignored;
        test_reset_abort;
        test_back_to_back;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
